sha256_job_arbiter: RTL
=======================

// Module: sha256_job_arbiter
// PURPOSE
// - Shares one simplified SHA-256 core between NUM_REQ requesters; one job = (message_addr, output_addr).
// - Round-robin arbitration, registered hand-off of addresses, start/done sequencing, per-requester completion pulse.
// - Sits between requester agents and the core's start/message_addr/output_addr/done pins.
// - Core memory traffic bypasses this block.
// PARAMETERS
// - NUM_REQ  default 4   number of requesters (2..16)
// - ADDR_W   default 16  word-address width, matches core message_addr/output_addr
// - ID_W     default $clog2(NUM_REQ)  width of grant_id
// PORTS
// - clk             in   1               single clock, rising edge
// - reset_n         in   1               asynchronous, active-low reset
// - req             in   NUM_REQ         per-requester job request, level
// - req_msg_addr    in   NUM_REQ*ADDR_W  flattened; slice i = requester i message address
// - req_out_addr    in   NUM_REQ*ADDR_W  flattened; slice i = requester i hash output address
// - ack             out  NUM_REQ         one-cycle pulse: job of requester i accepted, addresses captured
// - resp_valid      out  NUM_REQ         one-cycle pulse: hash of requester i written to memory
// - busy            out  1               high from ack until resp_valid, inclusive
// - grant_id        out  ID_W            index of the requester currently owning the core
// - core_start      out  1               to core start
// - core_msg_addr   out  ADDR_W          to core message_addr, registered
// - core_out_addr   out  ADDR_W          to core output_addr, registered
// - core_done       in   1               from core done; level, high while core idle
// BEHAVIOUR
// - Reset (async on negedge reset_n, any state): state=IDLE.
//   - ack, resp_valid, busy, core_start = 0; grant_id, core_msg_addr, core_out_addr = 0; rr_ptr = 0.
// - States: IDLE, START, WAIT_DONE, RESP.
// - IDLE: req is sampled only here, and only while core_done = 1.
//   - If any req bit is set: pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Next edge: capture the winner's addresses into core_msg_addr/core_out_addr, set grant_id.
//   - Same edge: pulse ack[winner] for one cycle, enter START.
//   - If core_done = 0 (core busy from an external source): stay in IDLE.
// - START: core_start=1 and held until core_done is sampled 0, then WAIT_DONE.
//   - Latency from req to core_start: 1 cycle.
// - WAIT_DONE: core_start=0; stay until core_done is sampled 1, then RESP.
// - RESP: resp_valid[grant_id]=1 for exactly one cycle; rr_ptr <= (grant_id+1) mod NUM_REQ; next state IDLE.
//   - Back-to-back: a new ack can occur on the cycle after RESP. Minimum job spacing is 3 cycles plus core run time.
// - busy = 1 in START, WAIT_DONE and RESP.
// - Requester handshake:
//   - Hold req and addresses stable until ack.
//   - May drop req after ack; a requester that drops req before ack simply loses its turn.
//   - req still high after its own resp_valid is treated as a new job. rr_ptr ensures other pending requesters are served first.
// - Address inputs are ignored outside the IDLE capture edge. Core addresses stay constant for the whole job.
// - At most one bit of ack and one bit of resp_valid is high in any cycle.
// - rr_ptr wrap: grant_id = NUM_REQ-1 sets rr_ptr to 0.
// - Mid-job reset: job is dropped silently, no resp_valid. Core shares reset_n.
// CONFIGURATION
// - Macro SHA_ARB_STATS_EN defined:
//   - Extra input stats_clr (1) and output job_count (NUM_REQ*16, flattened).
//   - Counter i increments on resp_valid[i] and saturates at 16'hFFFF.
//   - stats_clr=1 clears all counters next edge; clear has priority over a simultaneous increment.
//   - Reset value 0.
// - Macro SHA_ARB_STATS_EN undefined: stats_clr and job_count ports and their logic do not exist. All other behaviour is identical.
// TESTING
// Bench core model: done drops 1 cycle after start, rises 20 cycles later.
// - Single job: req=4'b0001, addr 16'h0000/16'h0020 -> ack[0] next cycle; core_start 1 cycle; core addrs 0000/0020; resp_valid[0] 1 cycle after done rises.
// - Contention: req=4'b1111 held after reset -> ack order 0,1,2,3,0 back-to-back; never two ack bits at once.
// - Fairness: req[0] permanently high, req[2] raised during job 0 -> next grant is 2, then 0.
// - Slow core: done stays high 5 cycles after start -> core_start held 5 cycles, single job, no duplicate ack.
// - Reset mid-job: reset_n low in WAIT_DONE -> all outputs 0 immediately; after release, req=4'b0100 -> ack[2] (rr_ptr=0).
// - SHA_ARB_STATS_EN: 3 jobs on requester 1 -> job_count[31:16]=3; stats_clr with a coincident resp_valid -> 0.

Source files
------------

// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core between NUM_REQ requesters.
// Optional per-requester job counters are enabled by defining SHA_ARB_STATS_EN.
module sha256_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_msg_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_out_addr,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      core_start,
  output logic [ADDR_W-1:0]         core_msg_addr,
  output logic [ADDR_W-1:0]         core_out_addr,
  input  logic                      core_done
`ifdef SHA_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*16-1:0]     job_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic                r_busy;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_core_start;
  logic [ADDR_W-1:0]   r_core_msg_addr;
  logic [ADDR_W-1:0]   r_core_out_addr;
  logic [ID_W-1:0]     r_rr_ptr;

  logic                w_any;
  logic [ID_W-1:0]     w_winner;
  logic [NUM_REQ-1:0]  w_winner_onehot;
  logic [ADDR_W-1:0]   w_msg_addr;
  logic [ADDR_W-1:0]   w_out_addr;

  // First set request found searching upward from r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_any    = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[ID_W-1:0]]) begin
        w_any    = 1'b1;
        w_winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_winner_onehot = '0;
    w_msg_addr      = '0;
    w_out_addr      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_winner_onehot[i] = 1'b1;
        w_msg_addr         = req_msg_addr[i*ADDR_W +: ADDR_W];
        w_out_addr         = req_out_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_ack           <= '0;
      r_resp_valid    <= '0;
      r_busy          <= 1'b0;
      r_grant_id      <= '0;
      r_core_start    <= 1'b0;
      r_core_msg_addr <= '0;
      r_core_out_addr <= '0;
      r_rr_ptr        <= '0;
    end else begin
      r_ack        <= '0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          // A core kept busy by another master blocks new grants.
          if (core_done && w_any) begin
            r_ack           <= w_winner_onehot;
            r_grant_id      <= w_winner;
            r_core_msg_addr <= w_msg_addr;
            r_core_out_addr <= w_out_addr;
            r_core_start    <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_START;
          end
        end
        S_START: begin
          if (!core_done) begin
            r_core_start <= 1'b0;
            r_state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (core_done) begin
            r_resp_valid <= NUM_REQ'(1) << r_grant_id;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack           = r_ack;
  assign resp_valid    = r_resp_valid;
  assign busy          = r_busy;
  assign grant_id      = r_grant_id;
  assign core_start    = r_core_start;
  assign core_msg_addr = r_core_msg_addr;
  assign core_out_addr = r_core_out_addr;

`ifdef SHA_ARB_STATS_EN
  logic [15:0] r_job_count [NUM_REQ];

  // Clear wins over a coincident completion; counters stick at all-ones.
  // NOTE: the counter array is small and architecturally visible, so it is reset
  // like any other register rather than left uninitialised like a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_job_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          r_job_count[i] <= '0;
        else if (r_resp_valid[i] && (r_job_count[i] != 16'hFFFF))
          r_job_count[i] <= r_job_count[i] + 16'd1;
      end
    end
  end

  always_comb begin
    job_count = '0;
    for (int i = 0; i < NUM_REQ; i++) job_count[i*16 +: 16] = r_job_count[i];
  end
`endif

endmodule
